csr_unit: RTL and testbench
===========================

# csr_unit

Machine-mode CSR file and interrupt controller sitting directly downstream of the MEM/WB pipeline register. It consumes the registered CSR write, return and retire controls at writeback, holds mstatus/mie/mip/mtvec/mepc plus the 64-bit cycle/instret counters, and serves combinational CSR reads to the execute stage. It decides interrupt entry, mret return and WFI sleep, and issues a one-cycle PC redirect to fetch.

## Interface
No parameters (XLEN fixed at 32).
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- stall  in  1  WB stage held; no CSR write, mret, retire or interrupt entry this cycle
- csr_we_i  in  1  CSR write at WB (from MEM/WB CSRWrite)
- csr_ret_i  in  1  mret at WB (from MEM/WB CSR_return)
- csr_waddr_i  in  12  CSR write address
- csr_wdata_i  in  32  CSR write data (final value; set/clear resolved upstream)
- retire_i  in  1  instruction retires at WB this cycle
- wfi_i  in  1  WFI at WB this cycle
- resume_pc_i  in  32  PC of oldest unretired instruction, saved to mepc on interrupt
- ext_irq_i  in  1  external interrupt, level
- timer_irq_i  in  1  timer interrupt, level
- csr_raddr_i  in  12  read address from EX
- csr_rdata_o  out  32  read data, combinational
- redirect_o  out  1  one-cycle PC redirect / pipeline flush
- redirect_pc_o  out  32  redirect target
- irq_taken_o  out  1  redirect is an interrupt entry (0 = mret)
- wfi_sleep_o  out  1  core sleeping; front end must hold

## Operation
- mstatus 0x300: MIE[3], MPIE[7] writable; MPP[12:11] hardwired 2'b11; other bits read 0.
- mie 0x304: MEIE[11], MTIE[7] writable; others 0.
- mtvec 0x305: direct mode; bits[1:0] forced 0.
- mepc 0x341: bits[1:0] forced 0.
- mip 0x344: read-only; MEIP[11]=ext_irq_i, MTIP[7]=timer_irq_i (live).
- mcycle/mcycleh 0xB00/0xB80, minstret/minstreth 0xB02/0xB82: writable halves. cycle/cycleh 0xC00/0xC80 and instret/instreth 0xC02/0xC82 are read-only aliases.
- Unknown addresses read 0; writes to them and to read-only CSRs are ignored.
- mcycle increments every cycle, including stall and sleep. minstret increments when retire_i & !stall. 64-bit, wraps 2^64-1 -> 0. A write to either half in the same cycle wins for that half; the other half keeps its old value and gets no carry.
- csr_rdata_o reflects register state before the current edge. There is no same-cycle write bypass; forwarding is external.
- Enabled pending: pend = (MEIE & ext_irq_i) | (MTIE & timer_irq_i). Interrupt entry requires MIE & pend & !stall & !csr_we_i & !csr_ret_i. Otherwise entry is deferred.
- Interrupt entry at the edge:
  - mepc <= resume_pc_i & ~3
  - MPIE <= MIE, MIE <= 0
  - next cycle: redirect_o=1, irq_taken_o=1, redirect_pc_o=mtvec
- mret (csr_ret_i & !stall) at the edge:
  - MIE <= MPIE, MPIE <= 1
  - next cycle: redirect_o=1, irq_taken_o=0, redirect_pc_o=mepc
- WFI FSM has two states, RUN and SLEEP.
  - RUN -> SLEEP on wfi_i & !stall & !pend.
  - SLEEP -> RUN when pend != 0, regardless of MIE.
  - WFI with pend already set is a NOP.
  - wfi_sleep_o = (state == SLEEP).
  - Interrupt entry is evaluated from RUN only, so entry happens no earlier than the cycle after wake.

## Timing
- Reset (sync, rst high at edge):
  - mstatus=0x0000_1800; mie, mtvec, mepc, counters = 0
  - state=RUN
  - redirect_o, irq_taken_o, wfi_sleep_o = 0; redirect_pc_o=0
- CSR write latency: 1 edge. Reading the same address in the next cycle returns the new value.
- redirect_o is registered, exactly one cycle high, one cycle after the decision edge. A second interrupt cannot follow back-to-back because MIE is already 0.
- With stall high, all architectural state except mcycle and the FSM wake transition holds.
- Simultaneous interrupt and mret: mret wins; the interrupt is re-evaluated after MIE is restored.

## Test plan
- Reset then read 0x300 -> 0x0000_1800; 0xB00 reads N after N cycles; 0x7C0 (unknown) reads 0.
- Write mtvec=0x0000_0103, mie=0x800, mstatus=0x8; assert ext_irq_i with resume_pc_i=0x200 -> one cycle later redirect_o=1, irq_taken_o=1, redirect_pc_o=0x100; mepc=0x200; mstatus=0x1880.
- From that state issue mret -> redirect_pc_o=0x200, irq_taken_o=0, mstatus=0x1888. Then hold ext_irq_i high, assert csr_we_i for one cycle -> entry deferred exactly one cycle.
- Write mcycle=0xFFFF_FFFF, mcycleh=0xFFFF_FFFF -> both read 0 two cycles later. Write minstret with retire_i=1 in the same cycle -> the written value is held, not +1.
- WFI with mie=0x80, MIE=0: wfi_sleep_o rises next cycle. Raise timer_irq_i -> wfi_sleep_o falls next cycle, no redirect.
- Pulse rst mid-sleep with irq pending -> all outputs 0, state RUN, mstatus=0x1800.

Source files
------------

// File: rtl/csr_unit.sv
// Machine-mode CSR file, interrupt entry/mret control and WFI sleep FSM at writeback.
// Latency: CSR reads are combinational; writes land at the next edge; redirect follows its decision edge by one cycle.
// Backpressure: stall freezes all architectural state except mcycle and the WFI wake transition.
module csr_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        csr_we_i,
    input  logic        csr_ret_i,
    input  logic [11:0] csr_waddr_i,
    input  logic [31:0] csr_wdata_i,
    input  logic        retire_i,
    input  logic        wfi_i,
    input  logic [31:0] resume_pc_i,
    input  logic        ext_irq_i,
    input  logic        timer_irq_i,
    input  logic [11:0] csr_raddr_i,
    output logic [31:0] csr_rdata_o,
    output logic        redirect_o,
    output logic [31:0] redirect_pc_o,
    output logic        irq_taken_o,
    output logic        wfi_sleep_o
);

    localparam logic [11:0] A_MSTATUS   = 12'h300;
    localparam logic [11:0] A_MIE       = 12'h304;
    localparam logic [11:0] A_MTVEC     = 12'h305;
    localparam logic [11:0] A_MEPC      = 12'h341;
    localparam logic [11:0] A_MIP       = 12'h344;
    localparam logic [11:0] A_MCYCLE    = 12'hB00;
    localparam logic [11:0] A_MCYCLEH   = 12'hB80;
    localparam logic [11:0] A_MINSTRET  = 12'hB02;
    localparam logic [11:0] A_MINSTRETH = 12'hB82;
    localparam logic [11:0] A_CYCLE     = 12'hC00;
    localparam logic [11:0] A_CYCLEH    = 12'hC80;
    localparam logic [11:0] A_INSTRET   = 12'hC02;
    localparam logic [11:0] A_INSTRETH  = 12'hC82;

    typedef enum logic {ST_RUN, ST_SLEEP} state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic        r_mie_bit;
    logic        r_mpie;
    logic        r_meie;
    logic        r_mtie;
    logic [31:0] r_mtvec;
    logic [31:0] r_mepc;
    logic [63:0] r_mcycle;
    logic [63:0] r_minstret;
    logic        r_redirect;
    logic        r_irq_taken;
    logic [31:0] r_redirect_pc;

    logic        w_wr_en;
    logic        w_pend;
    logic        w_take_irq;
    logic        w_do_mret;
    logic        w_retire;
    logic [63:0] w_mcycle_inc;
    logic [63:0] w_minstret_inc;
    logic [31:0] w_mstatus;
    logic [31:0] w_mie;
    logic [31:0] w_mip;

    assign w_wr_en        = csr_we_i & ~stall;
    assign w_pend         = (r_meie & ext_irq_i) | (r_mtie & timer_irq_i);
    assign w_do_mret      = csr_ret_i & ~stall;
    // mret and CSR writes at WB take precedence; interrupt entry retries afterwards
    assign w_take_irq     = (r_state == ST_RUN) & r_mie_bit & w_pend & ~stall & ~csr_we_i & ~csr_ret_i;
    assign w_retire       = retire_i & ~stall;
    assign w_mcycle_inc   = r_mcycle + 64'd1;
    assign w_minstret_inc = r_minstret + 64'd1;

    assign w_mstatus = {19'd0, 2'b11, 3'd0, r_mpie, 3'd0, r_mie_bit, 3'd0};
    assign w_mie     = {20'd0, r_meie, 3'd0, r_mtie, 7'd0};
    assign w_mip     = {20'd0, ext_irq_i, 3'd0, timer_irq_i, 7'd0};

    // mstatus MIE/MPIE: interrupt entry, then mret, then software write
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mie_bit <= 1'b0;
            r_mpie    <= 1'b0;
        end else if (w_take_irq) begin
            r_mpie    <= r_mie_bit;
            r_mie_bit <= 1'b0;
        end else if (w_do_mret) begin
            r_mie_bit <= r_mpie;
            r_mpie    <= 1'b1;
        end else if (w_wr_en && csr_waddr_i == A_MSTATUS) begin
            r_mie_bit <= csr_wdata_i[3];
            r_mpie    <= csr_wdata_i[7];
        end
    end

    // mie enables, mtvec and mepc; interrupt entry captures the resume PC
    always_ff @(posedge clk) begin
        if (rst) begin
            r_meie  <= 1'b0;
            r_mtie  <= 1'b0;
            r_mtvec <= 32'd0;
            r_mepc  <= 32'd0;
        end else begin
            if (w_wr_en && csr_waddr_i == A_MIE) begin
                r_meie <= csr_wdata_i[11];
                r_mtie <= csr_wdata_i[7];
            end
            if (w_wr_en && csr_waddr_i == A_MTVEC) begin
                r_mtvec <= csr_wdata_i & 32'hFFFF_FFFC;
            end
            if (w_take_irq) begin
                r_mepc <= resume_pc_i & 32'hFFFF_FFFC;
            end else if (w_wr_en && csr_waddr_i == A_MEPC) begin
                r_mepc <= csr_wdata_i & 32'hFFFF_FFFC;
            end
        end
    end

    // 64-bit counters; a half-write replaces that half and freezes the other for the cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mcycle   <= 64'd0;
            r_minstret <= 64'd0;
        end else begin
            if (w_wr_en && csr_waddr_i == A_MCYCLE) begin
                r_mcycle[31:0] <= csr_wdata_i;
            end else if (w_wr_en && csr_waddr_i == A_MCYCLEH) begin
                r_mcycle[63:32] <= csr_wdata_i;
            end else begin
                r_mcycle <= w_mcycle_inc;
            end

            if (w_wr_en && csr_waddr_i == A_MINSTRET) begin
                r_minstret[31:0] <= csr_wdata_i;
            end else if (w_wr_en && csr_waddr_i == A_MINSTRETH) begin
                r_minstret[63:32] <= csr_wdata_i;
            end else if (w_retire) begin
                r_minstret <= w_minstret_inc;
            end
        end
    end

    // WFI state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // WFI next state: sleep only when nothing enabled is pending; wake ignores MIE and stall
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RUN:   if (wfi_i && !stall && !w_pend) w_state_nxt = ST_SLEEP;
            ST_SLEEP: if (w_pend) w_state_nxt = ST_RUN;
            default:  w_state_nxt = ST_RUN;
        endcase
    end

    // one-cycle redirect pulse registered from the decision edge
    always_ff @(posedge clk) begin
        if (rst) begin
            r_redirect    <= 1'b0;
            r_irq_taken   <= 1'b0;
            r_redirect_pc <= 32'd0;
        end else begin
            r_redirect  <= w_take_irq | w_do_mret;
            r_irq_taken <= w_take_irq;
            if (w_take_irq) begin
                r_redirect_pc <= r_mtvec;
            end else if (w_do_mret) begin
                r_redirect_pc <= r_mepc;
            end else begin
                r_redirect_pc <= 32'd0;
            end
        end
    end

    // combinational read port for EX; unknown addresses read zero
    always_comb begin
        csr_rdata_o = 32'd0;
        case (csr_raddr_i)
            A_MSTATUS:              csr_rdata_o = w_mstatus;
            A_MIE:                  csr_rdata_o = w_mie;
            A_MTVEC:                csr_rdata_o = r_mtvec;
            A_MEPC:                 csr_rdata_o = r_mepc;
            A_MIP:                  csr_rdata_o = w_mip;
            A_MCYCLE,   A_CYCLE:    csr_rdata_o = r_mcycle[31:0];
            A_MCYCLEH,  A_CYCLEH:   csr_rdata_o = r_mcycle[63:32];
            A_MINSTRET, A_INSTRET:  csr_rdata_o = r_minstret[31:0];
            A_MINSTRETH, A_INSTRETH: csr_rdata_o = r_minstret[63:32];
            default:                csr_rdata_o = 32'd0;
        endcase
    end

    assign redirect_o    = r_redirect;
    assign irq_taken_o   = r_irq_taken;
    assign redirect_pc_o = r_redirect_pc;
    assign wfi_sleep_o   = (r_state == ST_SLEEP);

endmodule

// File: tb/tb_csr_unit.sv
// Directed bench for csr_unit: stimulus pushes expected read/output probes and redirects into queues.
// A negedge monitor pops and compares whenever a probe is armed or the DUT raises redirect_o.
// Redirect expectations carry the cycle they must appear in, so deferral timing is checked too.
module tb_csr_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        csr_we_i;
    logic        csr_ret_i;
    logic [11:0] csr_waddr_i;
    logic [31:0] csr_wdata_i;
    logic        retire_i;
    logic        wfi_i;
    logic [31:0] resume_pc_i;
    logic        ext_irq_i;
    logic        timer_irq_i;
    logic [11:0] csr_raddr_i;
    logic [31:0] csr_rdata_o;
    logic        redirect_o;
    logic [31:0] redirect_pc_o;
    logic        irq_taken_o;
    logic        wfi_sleep_o;

    csr_unit dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .csr_we_i     (csr_we_i),
        .csr_ret_i    (csr_ret_i),
        .csr_waddr_i  (csr_waddr_i),
        .csr_wdata_i  (csr_wdata_i),
        .retire_i     (retire_i),
        .wfi_i        (wfi_i),
        .resume_pc_i  (resume_pc_i),
        .ext_irq_i    (ext_irq_i),
        .timer_irq_i  (timer_irq_i),
        .csr_raddr_i  (csr_raddr_i),
        .csr_rdata_o  (csr_rdata_o),
        .redirect_o   (redirect_o),
        .redirect_pc_o(redirect_pc_o),
        .irq_taken_o  (irq_taken_o),
        .wfi_sleep_o  (wfi_sleep_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // probe entry: {check_pc, sleep, redirect, irq_taken, redirect_pc[31:0], rdata[31:0]}
    logic [67:0] probe_q[$];
    string       name_q[$];
    // redirect entry: {cycle[31:0], pc[31:0], irq_taken}
    logic [64:0] redir_q[$];
    logic        rd_vld = 1'b0;
    logic        done = 1'b0;

    int checks = 0;
    int failures = 0;

    logic [67:0] m_exp;
    logic [67:0] m_act;
    logic [64:0] m_rexp;
    logic [64:0] m_ract;
    string       m_name;

    // monitor: all comparisons and the summary happen here
    always @(negedge clk) begin
        if (rd_vld) begin
            checks++;
            if (probe_q.size() == 0) begin
                failures++;
                $display("FAIL probe_underflow: got probe armed, want queued expectation");
            end else begin
                m_exp  = probe_q.pop_front();
                m_name = name_q.pop_front();
                m_act  = {m_exp[67], wfi_sleep_o, redirect_o, irq_taken_o,
                          (m_exp[67] ? redirect_pc_o : m_exp[63:32]), csr_rdata_o};
                if (m_act !== m_exp) begin
                    failures++;
                    $display("FAIL %s: got sleep=%0b redir=%0b irq=%0b pc=%h rdata=%h, want sleep=%0b redir=%0b irq=%0b pc=%h rdata=%h",
                             m_name, m_act[66], m_act[65], m_act[64], m_act[63:32], m_act[31:0],
                             m_exp[66], m_exp[65], m_exp[64], m_exp[63:32], m_exp[31:0]);
                end
            end
        end
        if (redirect_o === 1'b1) begin
            checks++;
            if (redir_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_redirect: got redirect at cycle %0d pc=%h irq=%0b, want none",
                         cyc, redirect_pc_o, irq_taken_o);
            end else begin
                m_rexp = redir_q.pop_front();
                m_ract = {32'(cyc), redirect_pc_o, irq_taken_o};
                if (m_ract !== m_rexp) begin
                    failures++;
                    $display("FAIL redirect: got cycle=%0d pc=%h irq=%0b, want cycle=%0d pc=%h irq=%0b",
                             m_ract[64:33], m_ract[32:1], m_ract[0], m_rexp[64:33], m_rexp[32:1], m_rexp[0]);
                end
            end
        end
        if (done) begin
            checks++;
            if (redir_q.size() != 0) begin
                failures++;
                $display("FAIL missing_redirect: got %0d outstanding, want 0", redir_q.size());
            end
            checks++;
            if (probe_q.size() != 0) begin
                failures++;
                $display("FAIL missing_probe: got %0d outstanding, want 0", probe_q.size());
            end
            $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
            $finish;
        end else if (cyc > 2000) begin
            failures++;
            $display("FAIL timeout: got cycle %0d, want done before 2000", cyc);
            $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
            $finish;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        rd_vld    = 1'b0;
        csr_we_i  = 1'b0;
        csr_ret_i = 1'b0;
        wfi_i     = 1'b0;
        retire_i  = 1'b0;
        stall     = 1'b0;
    endtask

    task automatic probe(input string nm, input logic [11:0] a, input logic [31:0] d,
                         input logic sl, input logic rd, input logic it, input logic cpc);
        csr_raddr_i = a;
        rd_vld      = 1'b1;
        probe_q.push_back({cpc, sl, rd, it, 32'h0, d});
        name_q.push_back(nm);
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        csr_we_i    = 1'b1;
        csr_waddr_i = a;
        csr_wdata_i = d;
    endtask

    task automatic expect_redir(input logic [31:0] pc, input logic it);
        redir_q.push_back({32'(cyc + 1), pc, it});
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; csr_we_i = 1'b0; csr_ret_i = 1'b0;
        csr_waddr_i = 12'h0; csr_wdata_i = 32'h0; retire_i = 1'b0; wfi_i = 1'b0;
        resume_pc_i = 32'h0; ext_irq_i = 1'b0; timer_irq_i = 1'b0; csr_raddr_i = 12'h0;
        tick(); tick();

        // reset state and basic reads; mcycle is 0 in the first cycle after reset
        rst = 1'b0;
        probe("reset_mstatus", 12'h300, 32'h0000_1800, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        probe("unknown_7c0", 12'h7C0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(); tick();
        probe("mcycle_3", 12'hB00, 32'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();

        // configure: no same-cycle bypass, then new values one edge later
        wr(12'h305, 32'h0000_0103);
        probe("mtvec_no_bypass", 12'h305, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        wr(12'h304, 32'h0000_0800);
        probe("mtvec_aligned", 12'h305, 32'h0000_0100, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        wr(12'h300, 32'h0000_0008);
        probe("mie_meie", 12'h304, 32'h0000_0800, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();

        // external interrupt entry
        ext_irq_i = 1'b1; resume_pc_i = 32'h0000_0200;
        probe("mstatus_mie_set", 12'h300, 32'h0000_1808, 1'b0, 1'b0, 1'b0, 1'b0);
        expect_redir(32'h0000_0100, 1'b1);
        tick();
        ext_irq_i = 1'b0;
        probe("mepc_after_entry", 12'h341, 32'h0000_0200, 1'b0, 1'b1, 1'b1, 1'b0);
        tick();
        probe("mstatus_after_entry", 12'h300, 32'h0000_1880, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();

        // mret
        csr_ret_i = 1'b1;
        probe("mip_idle", 12'h344, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        expect_redir(32'h0000_0200, 1'b0);
        tick();
        probe("mstatus_after_mret", 12'h300, 32'h0000_1888, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();

        // pending interrupt deferred exactly one cycle by a CSR write
        ext_irq_i = 1'b1; resume_pc_i = 32'h0000_0300;
        wr(12'h7C0, 32'hDEAD_BEEF);
        probe("mip_meip", 12'h344, 32'h0000_0800, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        expect_redir(32'h0000_0100, 1'b1);
        probe("unknown_write_ignored", 12'h7C0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        ext_irq_i = 1'b0;
        probe("mepc_deferred", 12'h341, 32'h0000_0300, 1'b0, 1'b1, 1'b1, 1'b0);
        tick();

        // mcycle half writes and 64-bit wrap
        wr(12'hB00, 32'hFFFF_FFFF);
        tick();
        wr(12'hB80, 32'hFFFF_FFFF);
        probe("mcycle_lo_written", 12'hB00, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        probe("cycleh_written", 12'hC80, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        probe("mcycle_wrap_lo", 12'hB00, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        probe("cycleh_wrap_hi", 12'hC80, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();

        // minstret: retire counts, write wins over retire, stall blocks retire
        retire_i = 1'b1;
        probe("minstret_0", 12'hB02, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        retire_i = 1'b1;
        wr(12'hB02, 32'h0000_1234);
        probe("instret_1", 12'hC02, 32'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        retire_i = 1'b1; stall = 1'b1;
        probe("minstret_write_wins", 12'hB02, 32'h0000_1234, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        wr(12'hB82, 32'd5);
        probe("minstret_stall_hold", 12'hB02, 32'h0000_1234, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        probe("instreth_written", 12'hC82, 32'd5, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();

        // stalled write is dropped
        stall = 1'b1;
        wr(12'h305, 32'h0000_0400);
        tick();
        probe("mtvec_stall_hold", 12'h305, 32'h0000_0100, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();

        // WFI sleep and wake with MIE clear: no redirect on wake
        wr(12'h304, 32'h0000_0080);
        tick();
        wfi_i = 1'b1;
        probe("mie_mtie", 12'h304, 32'h0000_0080, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        probe("sleeping", 12'h300, 32'h0000_1880, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        timer_irq_i = 1'b1;
        probe("mip_mtip_asleep", 12'h344, 32'h0000_0080, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        probe("woken", 12'h344, 32'h0000_0080, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        wfi_i = 1'b1;
        tick();
        probe("wfi_pending_nop", 12'h304, 32'h0000_0080, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();

        // reset while asleep with an interrupt pending
        timer_irq_i = 1'b0; wfi_i = 1'b1;
        tick();
        rst = 1'b1; timer_irq_i = 1'b1;
        probe("asleep_before_rst", 12'h300, 32'h0000_1880, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        rst = 1'b0;
        probe("rst_mid_sleep", 12'h300, 32'h0000_1800, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        probe("rst_mie", 12'h304, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        probe("rst_mcycle_2", 12'hB00, 32'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        done = 1'b1;
    end

endmodule
